cpu_irq_ctrl: RTL and testbench

- Interrupt controller in front of the single-cycle CPU control unit.
- Collects N_SRC peripheral interrupt lines, latches rising edges as pending, applies a software mask and picks one source by fixed priority.
- Drives the control unit's IRQ input and holds it until the exception is taken.
- Blocks re-entry while the CPU is in kernel mode (PC[31]=1) and until the handler returns.

---
 rtl/cpu_irq_pkg.sv | 20 ++
 rtl/cpu_irq_ctrl_if.sv | 28 ++
 rtl/cpu_irq_ctrl_prio_enc.sv | 24 ++
 rtl/cpu_irq_ctrl.sv | 94 +++++++++
 tb/tb_cpu_irq_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_irq_pkg.sv
// Shared definitions for the CPU interrupt controller: FSM encodings, default sizes
// and the exception vector the PC mux jumps to when an interrupt is taken.
package cpu_irq_pkg;

  localparam int N_SRC_DEF = 4;
  localparam int ID_W_DEF  = 2;

  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } irq_state_t;

  function automatic logic [7:0] id_onehot(input logic [2:0] id);
    return 8'(1) << id;
  endfunction

endpackage

// File: rtl/cpu_irq_ctrl_if.sv
// Peripheral-lines / mask / control-unit signal bundle for the interrupt controller.
// master = CPU side driving strobes and lines, slave = the controller.
interface cpu_irq_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
);
  logic [N_SRC-1:0] irq_src;
  logic             mask_wr;
  logic [N_SRC-1:0] mask_wdata;
  logic             pc_high;
  logic             irq_ack;
  logic             eret;
  logic             irq_out;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic             in_service;

  modport master (
    output irq_src, mask_wr, mask_wdata, pc_high, irq_ack, eret,
    input  irq_out, irq_id, mask, pending, in_service
  );

  modport slave (
    input  irq_src, mask_wr, mask_wdata, pc_high, irq_ack, eret,
    output irq_out, irq_id, mask, pending, in_service
  );
endinterface

// File: rtl/cpu_irq_ctrl_prio_enc.sv
// Combinational lowest-index-wins priority encoder, zero latency.
// No flow control: valid is simply "any bit set".
module irq_prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] eligible,
  output logic             valid,
  output logic [ID_W-1:0]  sel
);

  // Scan from the top so the lowest set index is the last assignment to stick.
  always_comb begin
    valid = 1'b0;
    sel   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        sel   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Edge-latched, masked, fixed-priority interrupt request to the control unit; irq_out 2 cycles after a rise.
// Request held until irq_ack; withdrawn if the CPU enters kernel mode first; blocked until eret.
module cpu_irq_ctrl
  import cpu_irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  cpu_irq_ctrl_if.slave  bus
);

  irq_state_t       state, state_nxt;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] mask_q;
  logic [ID_W-1:0]  id_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic             sel_vld;
  logic [ID_W-1:0]  sel;
  logic             load_id;

  assign rise     = bus.irq_src & ~src_q;
  assign eligible = pending_q & mask_q;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .eligible (eligible),
    .valid    (sel_vld),
    .sel      (sel)
  );

  always_comb begin
    state_nxt = state;
    clr       = '0;
    load_id   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_vld && !bus.pc_high) begin
          state_nxt = ST_REQ;
          load_id   = 1'b1;
        end
      end
      ST_REQ: begin
        // Ack beats pc_high: the kernel entry in that cycle is this interrupt.
        if (bus.irq_ack) begin
          state_nxt = ST_SERVICE;
          clr       = N_SRC'(id_onehot(3'(id_q)));
        end else if (bus.pc_high) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.eret) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      id_q      <= '0;
    end else begin
      state     <= state_nxt;
      src_q     <= bus.irq_src;
      // A fresh rise on the source being cleared re-arms it.
      pending_q <= (pending_q & ~clr) | rise;
      if (bus.mask_wr) begin
        mask_q <= bus.mask_wdata;
      end
      if (load_id) begin
        id_q <= sel;
      end
    end
  end

  assign bus.irq_out    = (state == ST_REQ);
  assign bus.in_service = (state == ST_SERVICE);
  assign bus.irq_id     = id_q;
  assign bus.mask       = mask_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Randomised + directed bench for cpu_irq_ctrl with a behavioural model and a per-cycle scoreboard.
module tb_cpu_irq_ctrl;

  localparam int N = 4;

  typedef struct {
    logic       irq_out;
    logic       in_service;
    logic [1:0] irq_id;
    logic [3:0] mask;
    logic [3:0] pending;
  } exp_t;

  logic clk;
  logic reset;
  cpu_irq_ctrl_if #(.N_SRC(N), .ID_W(2)) bus();

  cpu_irq_ctrl #(.N_SRC(N), .ID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // Model of the controller's externally visible behaviour.
  logic [3:0] m_pend, m_mask, m_prev;
  bit         m_req, m_svc;
  int         m_id;

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s @%0t: got %0h want %0h", nm, $time, got, want);
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0;
    m_req = 0; m_svc = 0; m_id = 0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic mw, input logic [3:0] md,
                            input logic pch, input logic ak, input logic er);
    int win;
    logic [3:0] np;
    win = -1;
    for (int i = 0; i < N; i++)
      if (win < 0 && m_pend[i] && m_mask[i]) win = i;
    np = m_pend;
    if (m_req && ak) np[m_id] = 1'b0;
    for (int i = 0; i < N; i++)
      if (s[i] && !m_prev[i]) np[i] = 1'b1;
    if (m_req) begin
      if (ak) begin m_req = 0; m_svc = 1; end
      else if (pch) m_req = 0;
    end else if (m_svc) begin
      if (er) m_svc = 0;
    end else if (win >= 0 && !pch) begin
      m_req = 1; m_id = win;
    end
    m_pend = np;
    m_prev = s;
    if (mw) m_mask = md;
  endtask

  task automatic drive_zero();
    bus.irq_src = '0; bus.mask_wr = 0; bus.mask_wdata = '0;
    bus.pc_high = 0;  bus.irq_ack = 0; bus.eret = 0;
  endtask

  // One clock: drive inputs, advance model, queue the state expected after the edge.
  task automatic cyc(input logic [3:0] s, input logic mw, input logic [3:0] md,
                     input logic pch, input logic ak, input logic er);
    exp_t e;
    @(posedge clk);
    #3;
    bus.irq_src = s; bus.mask_wr = mw; bus.mask_wdata = md;
    bus.pc_high = pch; bus.irq_ack = ak; bus.eret = er;
    model_step(s, mw, md, pch, ak, er);
    e.irq_out = m_req; e.in_service = m_svc; e.irq_id = 2'(m_id);
    e.mask = m_mask; e.pending = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [3:0] s);
    for (int i = 0; i < n; i++) cyc(s, 0, 4'b0, 0, 0, 0);
  endtask

  task automatic do_ack(input logic [3:0] s);
    for (int i = 0; i < 8; i++) begin
      bit a;
      a = m_req;
      cyc(s, 0, 4'b0, 0, a, 0);
      if (a) break;
    end
  endtask

  task automatic do_eret(input logic [3:0] s);
    idle(2, s);
    cyc(s, 0, 4'b0, 0, 0, 1);
    idle(1, s);
  endtask

  // Scoreboard monitor: samples just after each edge and compares against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("irq_out",    int'(bus.irq_out),    int'(e.irq_out));
        chk("in_service", int'(bus.in_service), int'(e.in_service));
        chk("irq_id",     int'(bus.irq_id),     int'(e.irq_id));
        chk("mask",       int'(bus.mask),       int'(e.mask));
        chk("pending",    int'(bus.pending),    int'(e.pending));
      end
    end
  end

  initial begin
    drive_zero();
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_irq_out",    int'(bus.irq_out),    0);
    chk("rst_in_service", int'(bus.in_service), 0);
    chk("rst_irq_id",     int'(bus.irq_id),     0);
    chk("rst_mask",       int'(bus.mask),       0);
    chk("rst_pending",    int'(bus.pending),    0);
    @(posedge clk); #3 reset = 1'b1;

    // Single masked-in source: request, ack, return.
    cyc(4'b0000, 1, 4'b0010, 0, 0, 0);
    idle(2, 4'b0000);
    cyc(4'b0010, 0, 4'b0, 0, 0, 0);
    idle(2, 4'b0000);
    do_ack(4'b0000);
    do_eret(4'b0000);

    // Simultaneous rises: index 1 first, then index 3.
    cyc(4'b0000, 1, 4'b1111, 0, 0, 0);
    cyc(4'b1010, 0, 4'b0, 0, 0, 0);
    do_ack(4'b1010);
    do_eret(4'b1010);
    do_ack(4'b1010);
    do_eret(4'b0000);

    // Pending while masked, released by a mask write.
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0);
    cyc(4'b0100, 0, 4'b0, 0, 0, 0);
    idle(3, 4'b0100);
    cyc(4'b0100, 1, 4'b0100, 0, 0, 0);
    idle(2, 4'b0100);
    do_ack(4'b0100);
    do_eret(4'b0000);

    // Request withdrawn by kernel entry, re-raised; rise coincident with ack.
    cyc(4'b0000, 1, 4'b0001, 0, 0, 0);
    cyc(4'b0001, 0, 4'b0, 0, 0, 0);
    idle(1, 4'b0000);
    cyc(4'b0000, 0, 4'b0, 1, 0, 0);
    idle(2, 4'b0000);
    cyc(4'b0001, 0, 4'b0, 0, 1, 0);
    idle(3, 4'b0001);
    do_eret(4'b0001);
    do_ack(4'b0000);
    do_eret(4'b0000);

    // Build SERVICE with pending=1010, then reset asynchronously.
    cyc(4'b0000, 1, 4'b0010, 0, 0, 0);
    cyc(4'b1010, 0, 4'b0, 0, 0, 0);
    idle(1, 4'b1010);
    do_ack(4'b1010);
    cyc(4'b1000, 0, 4'b0, 0, 0, 0);
    cyc(4'b1010, 0, 4'b0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("pre_rst_in_service", int'(bus.in_service), 1);
    chk("pre_rst_pending",    int'(bus.pending),    4'b1010);
    #1;
    drive_zero();
    reset = 1'b0;
    #1;
    chk("arst_irq_out",    int'(bus.irq_out),    0);
    chk("arst_in_service", int'(bus.in_service), 0);
    chk("arst_irq_id",     int'(bus.irq_id),     0);
    chk("arst_mask",       int'(bus.mask),       0);
    chk("arst_pending",    int'(bus.pending),    0);
    model_reset();
    @(posedge clk); #3 reset = 1'b1;

    // Random traffic.
    begin
      logic [3:0] s;
      s = '0;
      for (int c = 0; c < 2000; c++) begin
        logic mw, pch, ak, er;
        logic [3:0] md;
        for (int b = 0; b < N; b++)
          if ($urandom_range(7) == 0) s[b] = ~s[b];
        mw  = ($urandom_range(15) == 0);
        md  = 4'($urandom);
        pch = ($urandom_range(9) == 0);
        ak  = m_req ? ($urandom_range(9) < 6) : ($urandom_range(19) == 0);
        er  = m_svc ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
        cyc(s, mw, md, pch, ak, er);
      end
    end

    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
